monobit_stim_gen: RTL and testbench

//  Transmit side of the monobit bit-stream interface: generates one framed block of test bits on

---
 rtl/monobit_stim_gen.sv | 199 +++++++++++++++++++
 tb/tb_monobit_stim_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/monobit_stim_gen.sv
// ---------------------------------------------------------------------------
// monobit_stim_gen
//
// Purpose:
//   Transmit side of the monobit bit-stream interface. On request it sends one
//   framed block of BLOCK_LEN test bits on epsilon_dat. Each bit is held for
//   BIT_PERIOD cycles so the stream lines up with the monobit checker's
//   sampling loop. The block is used for on-chip self-test of the checker.
//   The bit source is one of four patterns:
//     - a 16-bit LFSR
//     - all ones
//     - alternating bits, starting with 1
//     - an exact-weight pattern: ones_target ones, then zeros
//   The number of ones sent is reported on ones_count, so the expected checker
//   verdict can be predicted.
//
// Ports:
//   clk          in   1    clock; all state updates on the rising edge
//   rst          in   1    synchronous reset, active-high
//   start        in   1    one-cycle request; accepted only in IDLE
//   mode         in   2    pattern select, sampled when start is accepted:
//                          0=LFSR, 1=all-ones, 2=alternating, 3=weighted
//   seed         in   16   LFSR seed, sampled when start is accepted
//                          (a seed of 0 is replaced by 16'hACE1)
//   ones_target  in   CW   weighted mode: number of leading ones in the block
//   epsilon_dat  out  1    serial test bit to the checker
//   bit_strobe   out  1    high on the first cycle of each new bit
//   busy         out  1    high while a block is being sent
//   done         out  1    one-cycle pulse after the last bit period
//   ones_count   out  CW   ones emitted in the current or last block
// ---------------------------------------------------------------------------
module monobit_stim_gen #(
    parameter int BIT_PERIOD = 5,
    parameter int BLOCK_LEN  = 128,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [15:0]   seed,
    input  logic [CW-1:0] ones_target,
    output logic          epsilon_dat,
    output logic          bit_strobe,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] ones_count
);

    localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int BW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    localparam logic [15:0]   SEED_DEFAULT = 16'hACE1;
    localparam logic [PW-1:0] PHASE_LAST   = PW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST     = BW'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] phase_cnt, phase_cnt_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic [15:0]   lfsr, lfsr_n;
    logic [1:0]    mode_lat, mode_lat_n;
    logic [CW-1:0] target_lat, target_lat_n;
    logic          epsilon_n, strobe_n, busy_n, done_n;
    logic [CW-1:0] ones_n;

    logic [15:0]   seed_eff;
    logic [15:0]   lfsr_adv;
    logic [BW-1:0] bit_inc;

    // Pattern value for bit index k. In LFSR mode the bit is taken from the
    // LFSR state that is current for bit k. The weighted comparison is done
    // at CW bits, which is wide enough to hold every bit index. This is why
    // a target of BLOCK_LEN or more simply yields an all-ones block.
    function automatic logic pattern_bit(input logic [1:0]    m,
                                         input logic [15:0]   l,
                                         input logic [BW-1:0] k,
                                         input logic [CW-1:0] t);
        logic b;
        case (m)
            2'd0:    b = l[0];
            2'd1:    b = 1'b1;
            2'd2:    b = ~k[0];
            default: b = (CW'(k) < t);
        endcase
        return b;
    endfunction

    // Helper values: the effective seed, the LFSR state for the next bit
    // (right shift, with feedback for x^16+x^14+x^13+x^11+1 entering at
    // bit 15), and the index of the next bit.
    always_comb begin
        seed_eff = (seed == 16'h0000) ? SEED_DEFAULT : seed;
        lfsr_adv = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        bit_inc  = bit_cnt + BW'(1);
    end

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the values the outputs will show in the following cycle.
    always_comb begin
        state_n      = state;
        phase_cnt_n  = phase_cnt;
        bit_cnt_n    = bit_cnt;
        lfsr_n       = lfsr;
        mode_lat_n   = mode_lat;
        target_lat_n = target_lat;
        epsilon_n    = 1'b0;
        strobe_n     = 1'b0;
        busy_n       = 1'b0;
        done_n       = 1'b0;
        ones_n       = ones_count;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = RUN;
                    mode_lat_n   = mode;
                    target_lat_n = ones_target;
                    lfsr_n       = seed_eff;
                    phase_cnt_n  = '0;
                    bit_cnt_n    = '0;
                    ones_n       = '0;
                    epsilon_n    = pattern_bit(mode, seed_eff, '0, ones_target);
                    strobe_n     = 1'b1;
                    busy_n       = 1'b1;
                end
            end

            RUN: begin
                busy_n    = 1'b1;
                epsilon_n = epsilon_dat;
                // Count each bit once, on the cycle it is first presented.
                if (bit_strobe) begin
                    ones_n = ones_count + CW'(epsilon_dat);
                end
                if (phase_cnt == PHASE_LAST) begin
                    phase_cnt_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_n   = DONE;
                        busy_n    = 1'b0;
                        done_n    = 1'b1;
                        epsilon_n = 1'b0;
                    end else begin
                        bit_cnt_n = bit_inc;
                        lfsr_n    = lfsr_adv;
                        epsilon_n = pattern_bit(mode_lat, lfsr_adv, bit_inc, target_lat);
                        strobe_n  = 1'b1;
                    end
                end else begin
                    phase_cnt_n = phase_cnt + PW'(1);
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers. A reset aborts any block in flight at
    // once, and no done pulse is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            bit_cnt     <= '0;
            lfsr        <= SEED_DEFAULT;
            mode_lat    <= '0;
            target_lat  <= '0;
            epsilon_dat <= 1'b0;
            bit_strobe  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ones_count  <= '0;
        end else begin
            state       <= state_n;
            phase_cnt   <= phase_cnt_n;
            bit_cnt     <= bit_cnt_n;
            lfsr        <= lfsr_n;
            mode_lat    <= mode_lat_n;
            target_lat  <= target_lat_n;
            epsilon_dat <= epsilon_n;
            bit_strobe  <= strobe_n;
            busy        <= busy_n;
            done        <= done_n;
            ones_count  <= ones_n;
        end
    end

endmodule

// File: tb/tb_monobit_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_monobit_stim_gen
//
// Purpose:
//   Self-checking bench for monobit_stim_gen. A table of block requests is
//   applied first, followed by randomised blocks. Each block's bit stream,
//   strobe and busy framing, done timing and ones count are compared with a
//   reference model. The model builds the expected 128-bit pattern directly
//   from the pattern definitions. Hand-written sequences cover the
//   multi-cycle corner cases: start requests ignored mid-block and during
//   DONE, a reset in the middle of a block, and back-to-back blocks.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_monobit_stim_gen;

    localparam int BIT_PERIOD = 5;
    localparam int BLOCK_LEN  = 128;
    localparam int CW         = 8;
    localparam int RUN_CYCLES = BIT_PERIOD * BLOCK_LEN;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [15:0]   seed;
    logic [CW-1:0] ones_target;
    logic          epsilon_dat;
    logic          bit_strobe;
    logic          busy;
    logic          done;
    logic [CW-1:0] ones_count;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        int          mode;
        logic [15:0] seed;
        int          target;
        int          exp_ones;   // -1: take the ones count from the model
        bit          chk_first;
        logic [2:0]  exp_first;  // bit 0 is the first bit sent
    } vec_t;

    monobit_stim_gen #(
        .BIT_PERIOD (BIT_PERIOD),
        .BLOCK_LEN  (BLOCK_LEN),
        .CW         (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .seed        (seed),
        .ones_target (ones_target),
        .epsilon_dat (epsilon_dat),
        .bit_strobe  (bit_strobe),
        .busy        (busy),
        .done        (done),
        .ones_count  (ones_count)
    );

    always #5 clk = ~clk;

    // Reference pattern for one block, built straight from the pattern
    // definitions using integer arithmetic.
    function automatic logic [BLOCK_LEN-1:0] model_stream(input int m, input logic [15:0] s, input int t);
        logic [BLOCK_LEN-1:0] r;
        int sr;
        int fb;
        r  = '0;
        sr = (s == 16'h0000) ? 'hACE1 : int'(s);
        for (int k = 0; k < BLOCK_LEN; k++) begin
            case (m)
                0: begin
                    r[k] = sr[0];
                    fb   = (sr ^ (sr >> 2) ^ (sr >> 3) ^ (sr >> 5)) & 1;
                    sr   = (sr >> 1) | (fb << 15);
                end
                1:       r[k] = 1'b1;
                2:       r[k] = (k % 2 == 0);
                default: r[k] = (k < t);
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Run one block. The caller must be in an IDLE cycle, sampled 1 time
    // unit after a rising edge. With disturb set, the task pulses start and
    // changes mode/seed/ones_target mid-block, then pulses start again
    // during the DONE cycle. All of these must be ignored. The task returns
    // in the IDLE cycle that follows DONE, so a new start can be issued
    // immediately.
    task automatic applyStimulus(input string tag, input int m, input logic [15:0] s,
                                 input int t, input int exp_ones, input bit disturb,
                                 output logic [2:0] first_bits);
        logic [BLOCK_LEN-1:0] exp_bits;
        int err_stream = 0;
        int err_strobe = 0;
        int err_busy   = 0;
        int err_done   = 0;
        int want_ones;
        exp_bits  = model_stream(m, s, t);
        want_ones = (exp_ones < 0) ? $countones(exp_bits) : exp_ones;
        first_bits = '0;

        mode        = 2'(m);
        seed        = s;
        ones_target = CW'(t);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        checkOutput({tag, " ones_clear"}, int'(ones_count), 0);
        for (int c = 1; c <= RUN_CYCLES; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if ((c - 1) % BIT_PERIOD == 0 && (c - 1) / BIT_PERIOD < 3) begin
                first_bits[(c - 1) / BIT_PERIOD] = epsilon_dat;
            end
            if (epsilon_dat !== exp_bits[(c - 1) / BIT_PERIOD]) err_stream++;
            if (bit_strobe !== ((c - 1) % BIT_PERIOD == 0))     err_strobe++;
            if (busy !== 1'b1)                                  err_busy++;
            if (done !== 1'b0)                                  err_done++;
            if (disturb && c == 100) begin
                start       = 1'b1;
                mode        = ~mode;
                seed        = ~seed;
                ones_target = ~ones_target;
            end
            if (disturb && c == 101) start = 1'b0;
        end

        // Done cycle
        @(posedge clk);
        #1;
        checkOutput({tag, " done_pulse"}, int'(done), 1);
        if (busy !== 1'b0 || bit_strobe !== 1'b0 || epsilon_dat !== 1'b0) err_busy++;
        checkOutput({tag, " ones_final"}, int'(ones_count), want_ones);
        if (disturb) start = 1'b1;

        // Return to IDLE
        @(posedge clk);
        #1;
        start = 1'b0;
        if (done !== 1'b0) err_done++;
        if (busy !== 1'b0 || bit_strobe !== 1'b0 || epsilon_dat !== 1'b0) err_busy++;
        checkOutput({tag, " ones_hold"}, int'(ones_count), want_ones);

        checkOutput({tag, " stream_errs"}, err_stream, 0);
        checkOutput({tag, " strobe_errs"}, err_strobe, 0);
        checkOutput({tag, " busy_errs"},   err_busy,   0);
        checkOutput({tag, " done_errs"},   err_done,   0);
    endtask

    initial begin
        vec_t       vecs[10];
        logic [2:0] fb;
        int         done_seen;

        vecs[0] = '{0, 16'h0000,   0,  -1, 1'b1, 3'b001};
        vecs[1] = '{0, 16'hACE1,   0,  -1, 1'b1, 3'b001};
        vecs[2] = '{1, 16'h1234,   0, 128, 1'b0, 3'b000};
        vecs[3] = '{2, 16'h0000,   0,  64, 1'b1, 3'b101};
        vecs[4] = '{3, 16'h0000, 100, 100, 1'b0, 3'b000};
        vecs[5] = '{3, 16'h0000, 200, 128, 1'b0, 3'b000};
        vecs[6] = '{3, 16'h0000,   0,   0, 1'b1, 3'b000};
        vecs[7] = '{3, 16'h0000, 127, 127, 1'b0, 3'b000};
        vecs[8] = '{3, 16'h0000,   2,   2, 1'b1, 3'b011};
        vecs[9] = '{0, 16'h1234,   0,  -1, 1'b0, 3'b000};

        rst         = 1'b1;
        start       = 1'b0;
        mode        = '0;
        seed        = '0;
        ones_target = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs", {epsilon_dat, bit_strobe, busy, done}, 0);
        checkOutput("reset ones_count", int'(ones_count), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven blocks, issued back to back
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].mode, vecs[i].seed,
                          vecs[i].target, vecs[i].exp_ones, 1'b0, fb);
            if (vecs[i].chk_first) begin
                checkOutput($sformatf("vec%0d first_bits", i), int'(fb), int'(vecs[i].exp_first));
            end
        end

        // Start pulse and input changes mid-block, plus start during DONE
        applyStimulus("disturb", 3, 16'h0000, 37, 37, 1'b1, fb);
        applyStimulus("disturb_lfsr", 0, 16'hBEEF, 0, -1, 1'b1, fb);

        // Randomised blocks
        for (int r = 0; r < 6; r++) begin
            int          rm;
            logic [15:0] rs;
            int          rt;
            rm = int'($urandom_range(0, 3));
            rs = 16'($urandom);
            rt = int'($urandom_range(0, 255));
            applyStimulus($sformatf("rand%0d", r), rm, rs, rt, -1, 1'b0, fb);
        end

        // Reset at bit 50 of an all-ones block
        mode  = 2'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50 * BIT_PERIOD) @(posedge clk);
        #1;
        checkOutput("pre-reset bit50 strobe", {bit_strobe, busy}, 3);
        checkOutput("pre-reset ones_count", int'(ones_count), 50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid-reset outputs", {epsilon_dat, bit_strobe, busy, done}, 0);
        checkOutput("mid-reset ones_count", int'(ones_count), 0);
        done_seen = 0;
        for (int c = 0; c < RUN_CYCLES + 20; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checkOutput("no done after reset", done_seen, 0);

        // Recovery after the abort
        applyStimulus("post_reset", 2, 16'h0000, 0, 64, 1'b0, fb);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
